// File: rtl/game_over_score_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// game_over_score_ctrl_if : text-path and control signals of the score overlay
// Rev 1.0
// ---------------------------------------------------------------------------
interface game_over_score_ctrl_if #(
  parameter int SCORE_W = 10
);
  logic               game_over;
  logic [SCORE_W-1:0] score;
  logic [7:0]         char_yx;
  logic [7:0]         rom_char_yx;
  logic [6:0]         rom_char_code;
  logic [6:0]         char_code;
  logic               busy;
  logic               ready;

  modport master (
    output game_over, score, char_yx, rom_char_code,
    input  rom_char_yx, char_code, busy, ready
  );

  modport slave (
    input  game_over, score, char_yx, rom_char_code,
    output rom_char_yx, char_code, busy, ready
  );
endinterface
`default_nettype wire

// File: rtl/game_over_score_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// game_over_score_ctrl : game-over screen sequencer, binary->BCD score overlay
//   Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
// Rev 1.0
// ---------------------------------------------------------------------------
module game_over_score_ctrl #(
  parameter int         SCORE_W   = 10,
  parameter int         DIGITS    = 4,
  parameter logic [3:0] SCORE_ROW = 4'h4,
  parameter logic [3:0] SCORE_COL = 4'hB
) (
  input  logic                   clk,
  input  logic                   rst,
  game_over_score_ctrl_if.slave  bus
);

  localparam int BCD_W = DIGITS * 4;
  localparam int CNT_W = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(SCORE_W - 1);

  logic [1:0]         state_q, state_d;
  logic               go_q, go_d;
  logic [SCORE_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         yx_q, yx_d;

  logic               w_rise;
  logic [BCD_W-1:0]   w_bcd_adj;

  assign w_rise          = bus.game_over & ~go_q;
  assign bus.rom_char_yx = bus.char_yx;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      go_q    <= 1'b0;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      yx_q    <= '0;
    end else begin
      state_q <= state_d;
      go_q    <= go_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      yx_q    <= yx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (w_rise) state_d = S_CONV;
      S_CONV: begin
        if (!bus.game_over)         state_d = S_IDLE;
        else if (cnt_q == C_LAST_CNT) state_d = S_DONE;
      end
      S_DONE: if (!bus.game_over) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Double-dabble step: add-3 correction on each nibble >= 5, then shift
  always_comb begin
    w_bcd_adj = bcd_q;
    for (int n = 0; n < DIGITS; n++) begin
      if (bcd_q[n*4 +: 4] >= 4'd5)
        w_bcd_adj[n*4 +: 4] = 4'(bcd_q[n*4 +: 4] + 4'd3);
    end
  end

  always_comb begin
    go_d  = bus.game_over;
    yx_d  = bus.char_yx;
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (w_rise) begin
          bin_d = bus.score;
          bcd_d = '0;
          cnt_d = '0;
        end
      end
      S_CONV: begin
        if (!bus.game_over) begin
          bcd_d = '0;
        end else begin
          {bcd_d, bin_d} = {w_bcd_adj[BCD_W-2:0], bin_q, 1'b0};
          cnt_d          = cnt_q + 1'b1;
        end
      end
      S_DONE: if (!bus.game_over) bcd_d = '0;
      default: ;
    endcase
  end

  // Outputs: status flags and the score-field overlay on the ROM data
  always_comb begin : p_outputs
    logic       hit;
    logic       nz_seen;
    logic       blank;
    logic [3:0] nib;
    logic [6:0] sel;
    bus.busy  = (state_q == S_CONV);
    bus.ready = (state_q == S_DONE);
    hit       = 1'b0;
    nz_seen   = 1'b0;
    blank     = 1'b0;
    nib       = '0;
    sel       = '0;
    for (int i = 0; i < DIGITS; i++) begin
      nib     = bcd_q[(DIGITS-1-i)*4 +: 4];
      nz_seen = nz_seen | (nib != 4'd0);
`ifdef LEADING_ZERO_BLANK_EN
      blank   = !nz_seen && (i != DIGITS - 1);
`else
      blank   = 1'b0;
`endif
      if ((yx_q[7:4] == SCORE_ROW) &&
          (32'(yx_q[3:0]) == 32'(SCORE_COL) + 32'(i))) begin
        hit = 1'b1;
        sel = blank ? 7'h00 : 7'(7'h30 + {3'b000, nib});
      end
    end
    if (hit)
      bus.char_code = (state_q == S_DONE) ? sel : 7'h00;
    else
      bus.char_code = bus.rom_char_code;
  end

endmodule
`default_nettype wire

// File: tb/tb_game_over_score_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_game_over_score_ctrl : directed + random checks against a decimal model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_game_over_score_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  game_over_score_ctrl_if #(.SCORE_W(10)) bus ();

  game_over_score_ctrl #(
    .SCORE_W  (10),
    .DIGITS   (4),
    .SCORE_ROW(4'h4),
    .SCORE_COL(4'hB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Text ROM with one-cycle read latency
  logic [6:0] rom_mem [256];
  logic [6:0] rom_q;
  always @(posedge clk) rom_q <= rom_mem[bus.rom_char_yx];
  assign bus.rom_char_code = rom_q;

  int n_checks = 0;
  int n_pass   = 0;
  bit model_ready;
  int model_score;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expected character from decimal arithmetic on the converted score
  function automatic logic [6:0] exp_char(input logic [7:0] yx);
    int idx, p, d;
    if (yx[7:4] == 4'h4 && yx[3:0] >= 4'hB && yx[3:0] <= 4'hE) begin
      if (!model_ready) return 7'h00;
      idx = int'(yx[3:0]) - 11;
      p = 1;
      for (int k = 0; k < 3 - idx; k++) p = p * 10;
      d = (model_score / p) % 10;
`ifdef LEADING_ZERO_BLANK_EN
      if (idx < 3 && model_score < p) return 7'h00;
`endif
      return 7'(7'h30 + d);
    end
    return rom_mem[yx];
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic read_yx(input logic [7:0] yx, input string tag);
    bus.char_yx = yx;
    next_cycle();
    check(tag, bus.char_code, exp_char(yx));
  endtask

  task automatic check_field(input string tag);
    for (int c = 9; c < 16; c++) begin
      logic [7:0] yx;
      yx = {4'h4, 4'(c)};
      read_yx(yx, tag);
    end
  endtask

  // Raise game_over with score sc; optionally change score mid-conversion
  task automatic run_conv(input int sc, input int chg, input string tag);
    int busy_cycles;
    busy_cycles = 0;
    bus.score     = 10'(sc);
    bus.game_over = 1'b1;
    model_score   = sc;
    for (int k = 0; k < 40; k++) begin
      next_cycle();
      if (bus.busy) busy_cycles++;
      if (busy_cycles == 3 && chg >= 0) bus.score = 10'(chg);
      if (bus.ready) break;
    end
    check({tag, "_busy_cycles"}, busy_cycles, 10);
    check({tag, "_ready"}, bus.ready, 1'b1);
    check({tag, "_busy_low"}, bus.busy, 1'b0);
    model_ready = bus.ready;
  endtask

  task automatic drop_go(input string tag);
    bus.game_over = 1'b0;
    next_cycle();
    model_ready = 1'b0;
    check({tag, "_drop_ready"}, bus.ready, 1'b0);
  endtask

  initial begin
    logic [6:0] exp1023 [4];
    bit         saw_ready;
    int         nb;
    int         sc;
    logic [7:0] ryx;

    for (int i = 0; i < 256; i++) rom_mem[i] = 7'($urandom);
    rom_mem[8'h24] = 7'h47;
    rom_mem[8'h4A] = 7'h3A;
    exp1023[0] = 7'h31; exp1023[1] = 7'h30; exp1023[2] = 7'h32; exp1023[3] = 7'h33;

    rst = 1'b1;
    bus.game_over = 1'b0;
    bus.score     = '0;
    bus.char_yx   = '0;
    model_ready   = 1'b0;
    model_score   = 0;
    repeat (3) next_cycle();
    check("reset_busy", bus.busy, 1'b0);
    check("reset_ready", bus.ready, 1'b0);
    rst = 1'b0;
    next_cycle();

    // ROM passthrough
    read_yx(8'h24, "pt_24");
    check("pt_24_const", bus.char_code, 7'h47);
    read_yx(8'h4A, "pt_4A");
    check("pt_4A_const", bus.char_code, 7'h3A);
    read_yx(8'h4B, "idle_field");

    // Full-scale score
    run_conv(1023, -1, "s1023");
    for (int c = 0; c < 4; c++) begin
      bus.char_yx = 8'h4B + 8'(c);
      next_cycle();
      check("s1023_digit", bus.char_code, exp1023[c]);
    end
    check_field("s1023_field");
    repeat (5) next_cycle();
    check("hold_no_retrigger_ready", bus.ready, 1'b1);
    check("hold_no_retrigger_busy", bus.busy, 1'b0);
    drop_go("s1023");
    read_yx(8'h4E, "cleared_field");

    // Zero score
    run_conv(0, -1, "s0");
    check_field("s0_field");
    drop_go("s0");

    // Abort mid-conversion, then retry
    bus.score     = 10'd42;
    bus.game_over = 1'b1;
    nb = 0;
    for (int k = 0; k < 40 && nb < 5; k++) begin
      next_cycle();
      if (bus.busy) nb++;
    end
    bus.game_over = 1'b0;
    saw_ready = 1'b0;
    for (int k = 0; k < 15; k++) begin
      next_cycle();
      if (bus.ready) saw_ready = 1'b1;
    end
    check("abort_no_ready", saw_ready, 1'b0);
    model_ready = 1'b0;
    read_yx(8'h4D, "abort_field");
    run_conv(42, -1, "s42");
    check_field("s42_field");
    drop_go("s42");

    // Reset during conversion
    bus.score     = 10'd999;
    bus.game_over = 1'b1;
    repeat (4) next_cycle();
    rst = 1'b1;
    bus.game_over = 1'b0;
    next_cycle();
    check("rst_mid_busy", bus.busy, 1'b0);
    check("rst_mid_ready", bus.ready, 1'b0);
    rst = 1'b0;
    next_cycle();
    run_conv(7, -1, "s7");
    check_field("s7_field");
    drop_go("s7");

    // Score changes while converting must be ignored
    run_conv(42, 500, "chg");
    check_field("chg_field");
    drop_go("chg");

    // Randomized scores
    for (int r = 0; r < 10; r++) begin
      sc = int'($urandom_range(1023, 0));
      run_conv(sc, -1, "rnd");
      for (int c = 11; c < 15; c++) read_yx({4'h4, 4'(c)}, "rnd_digit");
      ryx = 8'($urandom);
      read_yx(ryx, "rnd_other");
      drop_go("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
